// File: rtl/vdp_port_if.sv
// CPU-side port interface of the MSX VDP: data/control port decode, VRAM address
// auto-increment, control registers R0..R7 and the vblank status/interrupt flag.
module vdp_port_if #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic              port_sel,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  input  logic              frame_tick,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_din,
  output logic              vram_wr,
  output logic              vram_rd,
  input  logic [7:0]        vram_dout,
  output logic [1:0]        mode,
  output logic [13:0]       name_table_addr,
  output logic [13:0]       font_addr,
  output logic              video_on,
  output logic              n_int
);

  typedef enum logic {FIRST, SECOND} latch_t;

  latch_t            latch, latch_nx;
  logic [7:0]        regs [8];
  logic [7:0]        tmp, rbuf;
  logic [ADDR_W-1:0] addr, setup_addr;
  logic              rd_q, wr_q, int_flag;
  logic [RD_LAT-1:0] rd_pend;
  logic              wr_edge, rd_edge, ctrl_wr, data_wr, data_rd, stat_rd;

  // A write edge wins over a simultaneous read edge.
  assign wr_edge    = cpu_wr & ~wr_q;
  assign rd_edge    = cpu_rd & ~rd_q & ~wr_edge;
  assign ctrl_wr    = wr_edge &  port_sel;
  assign data_wr    = wr_edge & ~port_sel;
  assign data_rd    = rd_edge & ~port_sel;
  assign stat_rd    = rd_edge &  port_sel;
  assign setup_addr = {cpu_din[ADDR_W-9:0], tmp};

  always_comb begin
    latch_nx = latch;
    if (data_wr || data_rd || stat_rd) latch_nx = FIRST;
    else if (ctrl_wr)                  latch_nx = (latch == FIRST) ? SECOND : FIRST;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Sample the strobes so a level still held after reset is not an edge.
      rd_q      <= cpu_rd;
      wr_q      <= cpu_wr;
      latch     <= FIRST;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      tmp       <= '0;
      rbuf      <= '0;
      addr      <= '0;
      int_flag  <= 1'b0;
      rd_pend   <= '0;
      cpu_dout  <= '0;
      vram_addr <= '0;
      vram_din  <= '0;
      vram_wr   <= 1'b0;
      vram_rd   <= 1'b0;
      n_int     <= 1'b1;
    end else begin
      rd_q    <= cpu_rd;
      wr_q    <= cpu_wr;
      latch   <= latch_nx;
      vram_wr <= 1'b0;
      vram_rd <= 1'b0;
      n_int   <= ~(int_flag & regs[1][5]);

      rd_pend[0] <= vram_rd;
      for (int i = 1; i < RD_LAT; i++) rd_pend[i] <= rd_pend[i-1];
      if (rd_pend[RD_LAT-1]) rbuf <= vram_dout;

      if (ctrl_wr) begin
        if (latch == FIRST)  tmp <= cpu_din;
        else if (cpu_din[7]) regs[cpu_din[2:0]] <= tmp;
        else if (cpu_din[6]) addr <= setup_addr;
        else begin
          // Read setup: prefetch at the new address, then step past it.
          vram_rd   <= 1'b1;
          vram_addr <= setup_addr;
          addr      <= setup_addr + ADDR_W'(1);
        end
      end

      if (data_wr) begin
        vram_wr   <= 1'b1;
        vram_addr <= addr;
        vram_din  <= cpu_din;
        addr      <= addr + ADDR_W'(1);
      end

      if (data_rd) begin
        cpu_dout  <= rbuf;
        vram_rd   <= 1'b1;
        vram_addr <= addr;
        addr      <= addr + ADDR_W'(1);
      end

      if (stat_rd) begin
        cpu_dout <= {int_flag, 7'b0};
        int_flag <= 1'b0;
      end
      if (frame_tick) int_flag <= 1'b1;
    end
  end

  always_comb begin
    if (regs[1][4])      mode = 2'd0;
    else if (regs[0][1]) mode = 2'd2;
    else if (regs[1][3]) mode = 2'd3;
    else                 mode = 2'd1;
  end

  assign name_table_addr = {regs[2][3:0], 10'b0};
  assign font_addr       = {regs[4][2:0], 11'b0};
  assign video_on        = regs[1][6];

endmodule

// File: tb/tb_vdp_port_if.sv
// Self-checking bench for vdp_port_if: register vector table, VRAM access scoreboard,
// and hand-written sequences for wrap, interrupt, latch-reset and strobe corners.
module tb_vdp_port_if;

  logic        clk = 0, reset = 1;
  logic        cpu_rd = 0, cpu_wr = 0, port_sel = 0, frame_tick = 0;
  logic [7:0]  cpu_din = 0, cpu_dout, vram_din, vram_dout;
  logic [13:0] vram_addr, name_table_addr, font_addr;
  logic        vram_wr, vram_rd, video_on, n_int;
  logic [1:0]  mode;

  vdp_port_if #(.ADDR_W(14), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .port_sel(port_sel),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .frame_tick(frame_tick),
    .vram_addr(vram_addr), .vram_din(vram_din), .vram_wr(vram_wr), .vram_rd(vram_rd),
    .vram_dout(vram_dout), .mode(mode), .name_table_addr(name_table_addr),
    .font_addr(font_addr), .video_on(video_on), .n_int(n_int)
  );

  always #5 clk = ~clk;

  // VRAM model: read data valid one cycle after the address is presented.
  logic [7:0] mem [16384];
  always @(posedge clk) begin
    if (vram_wr) mem[vram_addr] <= vram_din;
    vram_dout <= mem[vram_addr];
  end

  typedef struct { logic wr; logic [13:0] addr; logic [7:0] din; } acc_t;
  acc_t exp_q[$];
  int n_cmp = 0, n_bad = 0;
  logic [13:0] exp_addr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (vram_wr || vram_rd) begin
      acc_t e;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_vram: wr=%0b rd=%0b addr %0h, expected none", vram_wr, vram_rd, vram_addr);
      end else begin
        e = exp_q.pop_front();
        chk("vram_kind", {31'b0, vram_wr}, {31'b0, e.wr});
        chk("vram_addr", 32'(vram_addr), 32'(e.addr));
        if (e.wr) chk("vram_din", 32'(vram_din), 32'(e.din));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic sel, input logic wr, input logic rd, input logic [7:0] d);
    port_sel = sel; cpu_din = d; cpu_wr = wr; cpu_rd = rd;
    tick(2);
    cpu_wr = 0; cpu_rd = 0;
    tick(2);
  endtask

  task automatic ctrl(input logic [7:0] b); strobe(1, 1, 0, b); endtask
  task automatic srd(); strobe(1, 0, 1, 8'h00); endtask

  task automatic dwr(input logic [7:0] b);
    exp_q.push_back('{1'b1, exp_addr, b});
    exp_addr = exp_addr + 14'd1;
    strobe(0, 1, 0, b);
  endtask

  task automatic drd();
    exp_q.push_back('{1'b0, exp_addr, 8'h00});
    exp_addr = exp_addr + 14'd1;
    strobe(0, 0, 1, 8'h00);
  endtask

  typedef struct {
    logic [7:0] b0, b1; logic [1:0] mode; logic [13:0] nt, fa; logic von;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{8'h05, 8'h82, 2'd1, 14'h1400, 14'h0000, 1'b0};
    tbl[1] = '{8'h03, 8'h84, 2'd1, 14'h1400, 14'h1800, 1'b0};
    tbl[2] = '{8'h10, 8'h81, 2'd0, 14'h1400, 14'h1800, 1'b0};
    tbl[3] = '{8'h02, 8'h80, 2'd0, 14'h1400, 14'h1800, 1'b0};
    tbl[4] = '{8'h08, 8'h81, 2'd2, 14'h1400, 14'h1800, 1'b0};
    tbl[5] = '{8'h00, 8'h80, 2'd3, 14'h1400, 14'h1800, 1'b0};
    tbl[6] = '{8'h40, 8'h81, 2'd1, 14'h1400, 14'h1800, 1'b1};
    tbl[7] = '{8'h0F, 8'h82, 2'd1, 14'h3C00, 14'h1800, 1'b1};
    tbl[8] = '{8'hFF, 8'h84, 2'd1, 14'h3C00, 14'h3800, 1'b1};
    tbl[9] = '{8'hAB, 8'h83, 2'd1, 14'h3C00, 14'h3800, 1'b1};

    tick(3);
    reset = 0;
    tick(1);
    chk("rst_mode", 32'(mode), 1);
    chk("rst_video_on", 32'(video_on), 0);
    chk("rst_n_int", 32'(n_int), 1);
    chk("rst_name", 32'(name_table_addr), 0);
    chk("rst_font", 32'(font_addr), 0);
    chk("rst_cpu_dout", 32'(cpu_dout), 0);

    foreach (tbl[i]) begin
      ctrl(tbl[i].b0);
      ctrl(tbl[i].b1);
      chk($sformatf("tbl%0d_mode", i), 32'(mode), 32'(tbl[i].mode));
      chk($sformatf("tbl%0d_name", i), 32'(name_table_addr), 32'(tbl[i].nt));
      chk($sformatf("tbl%0d_font", i), 32'(font_addr), 32'(tbl[i].fa));
      chk($sformatf("tbl%0d_video_on", i), 32'(video_on), 32'(tbl[i].von));
    end

    // Write setup then two data writes with auto-increment.
    ctrl(8'h34); ctrl(8'h52); exp_addr = 14'h1234;
    dwr(8'hAA);
    dwr(8'hBB);

    // Preload 0x0000 and 0x3FFF; the second write wraps the address.
    ctrl(8'h00); ctrl(8'h40); exp_addr = 14'h0000;
    dwr(8'hC3);
    ctrl(8'hFF); ctrl(8'h7F); exp_addr = 14'h3FFF;
    dwr(8'h5A);
    chk("wrap_after_write", 32'(exp_q.size()), 0);

    // Read setup at 0x3FFF prefetches, address wraps, data reads return bytes.
    ctrl(8'hFF);
    exp_q.push_back('{1'b0, 14'h3FFF, 8'h00});
    exp_addr = 14'h0000;
    ctrl(8'h3F);
    drd();
    chk("rd_3fff", 32'(cpu_dout), 32'h5A);
    drd();
    chk("rd_0000", 32'(cpu_dout), 32'hC3);

    // Interrupt path.
    ctrl(8'h60); ctrl(8'h81);
    frame_tick = 1; tick(1); frame_tick = 0; tick(2);
    chk("irq_video_on", 32'(video_on), 1);
    chk("irq_mode", 32'(mode), 1);
    chk("irq_n_int_low", 32'(n_int), 0);
    srd();
    chk("stat_rd1", 32'(cpu_dout), 32'h80);
    chk("irq_n_int_clr", 32'(n_int), 1);
    srd();
    chk("stat_rd2", 32'(cpu_dout), 32'h00);

    // Status read coincident with frame_tick: set wins, old flag returned.
    port_sel = 1; cpu_rd = 1; frame_tick = 1;
    tick(1);
    frame_tick = 0;
    tick(1);
    cpu_rd = 0;
    tick(2);
    chk("tick_same_ret", 32'(cpu_dout), 32'h00);
    chk("tick_same_n_int", 32'(n_int), 0);
    srd();
    chk("tick_same_flag", 32'(cpu_dout), 32'h80);

    // Status read discards a half-written control pair.
    ctrl(8'h12); srd(); ctrl(8'h34); ctrl(8'h40); exp_addr = 14'h0034;
    dwr(8'h77);

    // Both strobes rise together on the data port: only the write happens.
    exp_q.push_back('{1'b1, exp_addr, 8'h99});
    exp_addr = exp_addr + 14'd1;
    strobe(0, 1, 1, 8'h99);

    // Reset mid-pair, with a data write strobe held high through reset.
    ctrl(8'h12);
    reset = 1; port_sel = 0; cpu_wr = 1; cpu_din = 8'hEE;
    tick(2);
    reset = 0;
    tick(3);
    cpu_wr = 0;
    tick(2);
    exp_addr = 14'h0000;
    ctrl(8'h00);
    chk("rst_mid_mode", 32'(mode), 1);
    chk("rst_mid_n_int", 32'(n_int), 1);
    ctrl(8'h81);
    chk("rst_mid_r1", 32'(mode), 1);
    ctrl(8'h10); ctrl(8'h81);
    chk("rst_mid_pair", 32'(mode), 0);
    dwr(8'hE1);

    tick(4);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

endmodule
